// File: rtl/ram_dual_param_if.sv
// rtl/ram_dual_param_if.sv - dual-port operand RAM bus: clear control plus two read/write ports
interface ram_dual_param_if #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 6
);
   logic              clr;
   logic              busy;
   logic              we_a;
   logic              re_a;
   logic [ADDR_W-1:0] addr_a;
   logic [DATA_W-1:0] din_a;
   logic [DATA_W-1:0] dout_a;
   logic              vld_a;
   logic              we_b;
   logic              re_b;
   logic [ADDR_W-1:0] addr_b;
   logic [DATA_W-1:0] din_b;
   logic [DATA_W-1:0] dout_b;
   logic              vld_b;

   modport master (
      output clr, we_a, re_a, addr_a, din_a, we_b, re_b, addr_b, din_b,
      input  busy, dout_a, vld_a, dout_b, vld_b
   );

   modport slave (
      input  clr, we_a, re_a, addr_a, din_a, we_b, re_b, addr_b, din_b,
      output busy, dout_a, vld_a, dout_b, vld_b
   );
endinterface

// File: rtl/ram_dual_param.sv
// rtl/ram_dual_param.sv - true dual-port operand RAM with clear sequencer and selectable read-during-write
module ram_dual_param #(
   parameter int DATA_W    = 8,
   parameter int ADDR_W    = 6,
   parameter int DEPTH     = 64,
   parameter int OUT_REG   = 0,
   parameter int RDW_MODE  = 0,
   parameter int INIT_ZERO = 1
) (
   input  logic           clk,
   input  logic           rst_n,
   ram_dual_param_if.slave bus
);
   typedef enum logic {S_IDLE, S_CLEAR} state_t;

   localparam state_t            RST_STATE = (INIT_ZERO != 0) ? S_CLEAR : S_IDLE;
   localparam logic [ADDR_W:0]   DEPTH_W   = (ADDR_W+1)'(DEPTH);
   localparam logic [ADDR_W-1:0] LAST      = ADDR_W'(DEPTH - 1);

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] cnt_q, cnt_d;
   logic              idle, clearing;
   logic              in_a, in_b, wr_a, wr_b, rd_a, rd_b;
   logic [DATA_W-1:0] rdata_a, rdata_b;
   logic [DATA_W-1:0] mem [DEPTH];

   logic              vld_a1_q, vld_b1_q;
   logic [DATA_W-1:0] dout_a1_q, dout_b1_q;

   // busy is masked by rst_n so it reads 0 in reset yet rises with the release edge
   assign idle     = rst_n && (state_q == S_IDLE);
   assign clearing = rst_n && (state_q == S_CLEAR);
   assign bus.busy = clearing;

   assign in_a = {1'b0, bus.addr_a} < DEPTH_W;
   assign in_b = {1'b0, bus.addr_b} < DEPTH_W;
   assign wr_a = idle && bus.we_a && in_a;
   assign wr_b = idle && bus.we_b && in_b;
   assign rd_a = idle && bus.re_a;
   assign rd_b = idle && bus.re_b;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         S_IDLE: begin
            if (bus.clr) begin
               state_d = S_CLEAR;
               cnt_d   = '0;
            end
         end
         S_CLEAR: begin
            if (cnt_q == LAST) begin
               state_d = S_IDLE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + ADDR_W'(1);
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= RST_STATE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Port A is written last so it wins a same-address collision
   always_ff @(posedge clk) begin
      if (clearing) begin
         mem[cnt_q] <= '0;
      end else begin
         if (wr_b) mem[bus.addr_b] <= bus.din_b;
         if (wr_a) mem[bus.addr_a] <= bus.din_a;
      end
   end

   always_comb begin
      rdata_a = '0;
      rdata_b = '0;
      if (in_a) rdata_a = mem[bus.addr_a];
      if (in_b) rdata_b = mem[bus.addr_b];
      if (RDW_MODE != 0) begin
         if (wr_b && (bus.addr_b == bus.addr_a)) rdata_a = bus.din_b;
         if (wr_a)                               rdata_a = bus.din_a;
         if (wr_b)                               rdata_b = bus.din_b;
         if (wr_a && (bus.addr_a == bus.addr_b)) rdata_b = bus.din_a;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_a1_q  <= 1'b0;
         vld_b1_q  <= 1'b0;
         dout_a1_q <= '0;
         dout_b1_q <= '0;
      end else begin
         vld_a1_q <= rd_a;
         vld_b1_q <= rd_b;
         if (rd_a) dout_a1_q <= rdata_a;
         if (rd_b) dout_b1_q <= rdata_b;
      end
   end

   generate
      if (OUT_REG != 0) begin : g_oreg
         logic              vld_a2_q, vld_b2_q;
         logic [DATA_W-1:0] dout_a2_q, dout_b2_q;

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               vld_a2_q  <= 1'b0;
               vld_b2_q  <= 1'b0;
               dout_a2_q <= '0;
               dout_b2_q <= '0;
            end else begin
               vld_a2_q <= vld_a1_q;
               vld_b2_q <= vld_b1_q;
               if (vld_a1_q) dout_a2_q <= dout_a1_q;
               if (vld_b1_q) dout_b2_q <= dout_b1_q;
            end
         end

         assign bus.vld_a  = vld_a2_q;
         assign bus.vld_b  = vld_b2_q;
         assign bus.dout_a = dout_a2_q;
         assign bus.dout_b = dout_b2_q;
      end else begin : g_noreg
         assign bus.vld_a  = vld_a1_q;
         assign bus.vld_b  = vld_b1_q;
         assign bus.dout_a = dout_a1_q;
         assign bus.dout_b = dout_b1_q;
      end
   endgenerate
endmodule
